// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle control unit and the datapath.
// The controller (master) reads the exported instruction word and drives every
// datapath control, plus the halt/retire/state status used for debug.
interface control_fsm_if #(
  parameter int CNT_W = 16
) ();

  logic [31:0]      instr;
  logic             PCUpdate;
  logic             regDest;
  logic             writeSP;
  logic             readSP;
  logic             updateSP;
  logic             writeReg;
  logic             aluSource;
  logic             PM4;
  logic             spmmux;
  logic             retMem;
  logic             memRead;
  logic             memWrite;
  logic             memReg;
  logic             spmux;
  logic             moveReg;
  logic             jump;
  logic             retPC;
  logic             haltPC;
  logic [1:0]       branch;
  logic [3:0]       aluOp;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  instr,
    output PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource,
           PM4, spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg,
           jump, retPC, haltPC, branch, aluOp, halted, retired, state
  );

  modport slave (
    output instr,
    input  PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource,
           PM4, spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg,
           jump, retPC, haltPC, branch, aluOp, halted, retired, state
  );

endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH, DECODE, EXEC, MEM and WB and drives the datapath controls.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FETCH  | instruction being fetched; all controls low
//   DECODE | opcode/funct latched at the end of this cycle; readSP strobe
//   EXEC   | level controls valid from the latched opcode
//   MEM    | level controls held; memRead/memWrite strobes
//   WB     | level controls held; writeReg/writeSP/PCUpdate strobes
//   HALT   | absorbing; haltPC and halted high until reset
module control_fsm #(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } stateT;

  stateT            curState, nextState;
  logic [5:0]       opReg;
  logic [3:0]       functReg;
  logic [CNT_W-1:0] retiredCnt;

  // decoded per-instruction attributes (from the latched opcode)
  logic [3:0] dAluOp;
  logic [1:0] dBranch;
  logic       dRegDest, dAluSource, dPM4, dSpmux, dMoveReg, dMemReg;
  logic       dJump, dRetPC, dRetMem, dUpdateSP;
  logic       dWriteReg, dWriteSP, dMemRead, dMemWrite, dHalt;
  logic       liveReadSP;

  // outputs computed combinationally from state
  logic [3:0] aluOp;
  logic [1:0] branch;
  logic       regDest, aluSource, PM4, spmmux, spmux, moveReg, memReg;
  logic       jump, retPC, retMem, updateSP;
  logic       writeReg, writeSP, readSP, memRead, memWrite, PCUpdate, haltPC;
  logic       halted;

  // instr bits between the opcode and funct fields are datapath-only
  logic unusedInstr;
  assign unusedInstr = ^bus.instr[25:4];

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curState <= FETCH;
    else        curState <= nextState;
  end

  // latch opcode and funct on the edge that leaves DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opReg    <= 6'd0;
      functReg <= 4'd0;
    end else if (curState == DECODE) begin
      opReg    <= bus.instr[31:26];
      functReg <= bus.instr[3:0];
    end
  end

  // retired-instruction counter; every WB leaves to FETCH or HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                retiredCnt <= '0;
    else if (curState == WB)   retiredCnt <= retiredCnt + CNT_W'(1);
  end

  // opcode decode into per-instruction attributes
  always_comb begin
    dAluOp     = 4'd0;
    dBranch    = 2'd0;
    dRegDest   = 1'b0;
    dAluSource = 1'b0;
    dPM4       = 1'b0;
    dSpmux     = 1'b0;
    dMoveReg   = 1'b0;
    dMemReg    = 1'b0;
    dJump      = 1'b0;
    dRetPC     = 1'b0;
    dRetMem    = 1'b0;
    dUpdateSP  = 1'b0;
    dWriteReg  = 1'b0;
    dWriteSP   = 1'b0;
    dMemRead   = 1'b0;
    dMemWrite  = 1'b0;
    dHalt      = 1'b0;
    casez (opReg)
      6'b000000: begin
        dAluOp = functReg; dAluSource = 1'b1; dRegDest = 1'b1; dWriteReg = 1'b1;
      end
      6'b01????: begin
        dAluOp = opReg[3:0]; dWriteReg = 1'b1;
      end
      6'b100000: begin
        dMemRead = 1'b1; dMemReg = 1'b1; dWriteReg = 1'b1;
      end
      6'b100001: dMemWrite = 1'b1;
      6'b100010: begin
        dMoveReg = 1'b1; dRegDest = 1'b1; dWriteReg = 1'b1;
      end
      6'b100011: begin
        dSpmux = 1'b1; dPM4 = 1'b1; dMemWrite = 1'b1; dWriteSP = 1'b1;
      end
      6'b100100: begin
        dSpmux = 1'b1; dMemRead = 1'b1; dMemReg = 1'b1;
        dWriteReg = 1'b1; dWriteSP = 1'b1;
      end
      6'b1010??: begin
        dBranch = opReg[1:0]; dAluSource = 1'b1;
      end
      6'b110000: dJump = 1'b1;
      6'b110001: begin
        dJump = 1'b1; dRetMem = 1'b1; dUpdateSP = 1'b1;
        dMemWrite = 1'b1; dWriteSP = 1'b1;
      end
      6'b110010: begin
        dMemRead = 1'b1; dMemReg = 1'b1; dRetPC = 1'b1;
      end
      6'b111111: dHalt = 1'b1;
      default:   dHalt = HALT_ON_ILLEGAL;
    endcase
  end

  // stack-pointer read is needed in DECODE, before the opcode is latched
  always_comb begin
    liveReadSP = 1'b0;
    case (bus.instr[31:26])
      6'b100011, 6'b100100, 6'b110010: liveReadSP = 1'b1;
      default:                         liveReadSP = 1'b0;
    endcase
  end

  // next-state and control outputs
  always_comb begin
    nextState = curState;
    aluOp     = 4'd0;
    branch    = 2'd0;
    regDest   = 1'b0;
    aluSource = 1'b0;
    PM4       = 1'b0;
    spmmux    = 1'b0;
    spmux     = 1'b0;
    moveReg   = 1'b0;
    memReg    = 1'b0;
    jump      = 1'b0;
    retPC     = 1'b0;
    retMem    = 1'b0;
    updateSP  = 1'b0;
    writeReg  = 1'b0;
    writeSP   = 1'b0;
    readSP    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    PCUpdate  = 1'b0;
    haltPC    = 1'b0;
    halted    = 1'b0;
    case (curState)
      FETCH:  nextState = DECODE;
      DECODE: begin
        nextState = EXEC;
        readSP    = liveReadSP;
      end
      EXEC:   nextState = MEM;
      MEM: begin
        nextState = WB;
        memRead   = dMemRead;
        memWrite  = dMemWrite;
      end
      WB: begin
        nextState = dHalt ? HALT : FETCH;
        writeReg  = dWriteReg;
        writeSP   = dWriteSP;
        PCUpdate  = 1'b1;
        haltPC    = dHalt;
      end
      HALT: begin
        nextState = HALT;
        haltPC    = 1'b1;
        halted    = 1'b1;
      end
      default: nextState = FETCH;
    endcase
    // level controls are held for the whole EXEC..WB window
    if (curState == EXEC || curState == MEM || curState == WB) begin
      aluOp     = dAluOp;
      branch    = dBranch;
      regDest   = dRegDest;
      aluSource = dAluSource;
      PM4       = dPM4;
      spmux     = dSpmux;
      moveReg   = dMoveReg;
      memReg    = dMemReg;
      jump      = dJump;
      retPC     = dRetPC;
      retMem    = dRetMem;
      updateSP  = dUpdateSP;
    end
  end

  assign bus.aluOp     = aluOp;
  assign bus.branch    = branch;
  assign bus.regDest   = regDest;
  assign bus.aluSource = aluSource;
  assign bus.PM4       = PM4;
  assign bus.spmmux    = spmmux;
  assign bus.spmux     = spmux;
  assign bus.moveReg   = moveReg;
  assign bus.memReg    = memReg;
  assign bus.jump      = jump;
  assign bus.retPC     = retPC;
  assign bus.retMem    = retMem;
  assign bus.updateSP  = updateSP;
  assign bus.writeReg  = writeReg;
  assign bus.writeSP   = writeSP;
  assign bus.readSP    = readSP;
  assign bus.memRead   = memRead;
  assign bus.memWrite  = memWrite;
  assign bus.PCUpdate  = PCUpdate;
  assign bus.haltPC    = haltPC;
  assign bus.halted    = halted;
  assign bus.retired   = retiredCnt;
  assign bus.state     = curState;

endmodule
